tlul_gpio: RTL and testbench
============================

# tlul_gpio

TL-UL device-side responder implementing the GPIO register block, attached behind the crossbar's GPIO port (driven by the data-memory socket). It accepts TL-UL Get/PutFullData/PutPartialData requests, answers with AccessAck/AccessAckData one cycle later, and owns the GPIO pin state. It synchronizes pin inputs, detects rising edges, and raises a level interrupt.

## Interface
- NumGpio, 32, number of implemented pins (1..32); register bits at or above NumGpio read 0 and ignore writes
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, synchronous, active-high
- tl_i  in  tlul_pkg::tl_h2d_t  request channel A plus d_ready
- tl_o  out  tlul_pkg::tl_d2h_t  response channel D plus a_ready
- gpio_i  in  NumGpio  asynchronous pin inputs
- gpio_o  out  NumGpio  output data (DATA_OUT)
- gpio_oe_o  out  NumGpio  output enables (DATA_OE)
- intr_o  out  1  registered |(INTR_STATE & INTR_ENABLE)

## Operation
- Register map, offset = a_address[4:0]:
  - 0x00 DATA_IN: RO, synchronized pins
  - 0x04 DATA_OUT: RW
  - 0x08 DATA_OE: RW
  - 0x0C INTR_STATE: RW1C; bit set on a rising edge of the synchronized input
  - 0x10 INTR_ENABLE: RW
  - 0x14 INTR_TEST: WO, reads 0; a written 1 sets the matching INTR_STATE bit
- Only a_address[4:0] is decoded; upper bits are the crossbar's concern.
- Writes honour a_mask per byte, for both PutFull and PutPartial. For RW1C and INTR_TEST, masked-off bytes have no effect.
- Opcode mapping:
  - Get -> AccessAckData, d_data = register value
  - Put -> AccessAck, d_data = 0
- Error response (d_error=1, d_data=0, no side effect on any register) for any of:
  - offset > 0x14
  - a_address[1:0] != 0
  - opcode not in {Get, PutFull, PutPartial}
  - write to DATA_IN
- Error responses still carry the matching d_opcode.
- d_source and d_size echo the accepted a_source and a_size. d_param, d_sink, d_user are 0.
- Input path: two flops (sync1, sync2), then a third flop (prev). Rising edge = sync2 & ~prev.
- Simultaneous events on the same INTR_STATE bit: a hardware edge set or INTR_TEST set wins over a W1C clear.

## Timing
- Reset values: all registers 0, d_valid 0, a_ready 1, intr_o 0, gpio_o 0, gpio_oe_o 0, sync/prev flops 0.
- Handshake: a_ready = ~d_valid | d_ready. A request is accepted when a_valid & a_ready.
- Accepted request produces d_valid on the next cycle. Register side effects are visible in the same next cycle.
- Throughput: one transaction per cycle while d_ready is held high.
- While d_valid & ~d_ready, all D-channel fields hold stable and a_ready = 0.
- Read data is sampled at acceptance. A DATA_IN change after acceptance does not alter a pending response.
- gpio_i to DATA_IN latency: 2 cycles. To INTR_STATE set: 3 cycles. To intr_o: 4 cycles.
- A write to INTR_ENABLE or INTR_STATE is reflected on intr_o one cycle after the register updates.
- Reset asserted mid-transaction drops any pending response: d_valid = 0 on the cycle after rst_i is sampled high, with no response for that request.

## Structure
- gpio_reg_pkg: register offset localparams (GPIO_DATA_IN ... GPIO_INTR_TEST) and register-map width.
- TL-UL opcode enums and channel structs come from tlul_pkg; they are not redefined here.
- One sub-module, gpio_sync: parameterized-width two-flop synchronizer plus prev flop, outputting sync2 and the rise vector.
- Register file, request decode and response register stay in tlul_gpio.

## Test plan
- Reset: assert rst_i for 2 cycles with pins toggling. Required: every output at its reset value and intr_o = 0.
- Write/read and throughput: PutFull 0xA5A5_00FF to 0x04, then Get 0x04. Required: gpio_o = 0xA5A5_00FF, AccessAckData returning 0xA5A5_00FF, back-to-back at one transaction per cycle with d_ready = 1.
- Partial write: PutPartial 0xFFFF_FFFF with mask 4'b0010 to 0x08 from 0. Required: gpio_oe_o = 0x0000_FF00.
- Errors: Get to 0x18, Put to 0x02, and Put to 0x00. Required: d_error = 1 and d_data = 0 on each, with no register change.
- Interrupt: INTR_ENABLE = 0x1, then gpio_i[0] rises. Required: intr_o = 1 four cycles later.
  - W1C of 0x1 clears it, with intr_o = 0 one cycle after the register clears.
  - A W1C on the same cycle as a new edge leaves the bit set.
- Backpressure and reset: hold d_ready = 0 after a Get. Required: D fields stable and a_ready = 0 for 5 cycles.
  - Then pulse rst_i. Required: d_valid = 0 on the next cycle.

Source files
------------

// File: rtl/gpio_reg_pkg.sv
// GPIO register map: word offsets within the 32-byte window and register width.
package gpio_reg_pkg;

  localparam int GpioRegW  = 32;
  localparam int GpioAddrW = 5;

  localparam logic [GpioAddrW-1:0] GPIO_DATA_IN     = 5'h00;
  localparam logic [GpioAddrW-1:0] GPIO_DATA_OUT    = 5'h04;
  localparam logic [GpioAddrW-1:0] GPIO_DATA_OE     = 5'h08;
  localparam logic [GpioAddrW-1:0] GPIO_INTR_STATE  = 5'h0C;
  localparam logic [GpioAddrW-1:0] GPIO_INTR_ENABLE = 5'h10;
  localparam logic [GpioAddrW-1:0] GPIO_INTR_TEST   = 5'h14;

  // Highest implemented offset; anything above decodes as an error.
  localparam logic [GpioAddrW-1:0] GPIO_LAST_OFFSET = GPIO_INTR_TEST;

endpackage

// File: rtl/tlul_pkg.sv
// TL-UL channel definitions shared by hosts, crossbar and device responders.
package tlul_pkg;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_SZW = 2;
  localparam int TL_DBW = TL_DW / 8;
  localparam int TL_AUW = 16;
  localparam int TL_DUW = 16;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    ArithmeticData = 3'h2,
    LogicalData    = 3'h3,
    Get            = 3'h4,
    Intent         = 3'h5
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic                a_valid;
    tl_a_op_e            a_opcode;
    logic [2:0]          a_param;
    logic [TL_SZW-1:0]   a_size;
    logic [TL_AIW-1:0]   a_source;
    logic [TL_AW-1:0]    a_address;
    logic [TL_DBW-1:0]   a_mask;
    logic [TL_DW-1:0]    a_data;
    logic [TL_AUW-1:0]   a_user;
    logic                d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic                d_valid;
    tl_d_op_e            d_opcode;
    logic [2:0]          d_param;
    logic [TL_SZW-1:0]   d_size;
    logic [TL_AIW-1:0]   d_source;
    logic [TL_DIW-1:0]   d_sink;
    logic [TL_DW-1:0]    d_data;
    logic [TL_DUW-1:0]   d_user;
    logic                d_error;
    logic                a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/gpio_sync.sv
// Two-flop pin synchronizer plus a history flop for rising-edge detection.
module gpio_sync #(
  parameter int Width = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [Width-1:0] i_d,
  output logic [Width-1:0] o_sync,
  output logic [Width-1:0] o_rise
);

  logic [Width-1:0] r_sync1;
  logic [Width-1:0] r_sync2;
  logic [Width-1:0] r_prev;

  // Shift pins through sync1 -> sync2 -> prev; all cleared on reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= i_d;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_sync = r_sync2;
  assign o_rise = r_sync2 & ~r_prev;

endmodule

// File: rtl/tlul_gpio.sv
// TL-UL device responder for the GPIO block: register file, request decode,
// single-entry response register, pin synchronizer and level interrupt.
module tlul_gpio
  import tlul_pkg::*;
  import gpio_reg_pkg::*;
#(
  parameter int NumGpio = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  tl_h2d_t            tl_i,
  output tl_d2h_t            tl_o,
  input  logic [NumGpio-1:0] gpio_i,
  output logic [NumGpio-1:0] gpio_o,
  output logic [NumGpio-1:0] gpio_oe_o,
  output logic               intr_o
);

  // Synchronized pins and their rising edges
  logic [NumGpio-1:0] w_data_in;
  logic [NumGpio-1:0] w_rise;

  gpio_sync #(.Width(NumGpio)) u_sync (
    .i_clk  (clk_i),
    .i_rst  (rst_i),
    .i_d    (gpio_i),
    .o_sync (w_data_in),
    .o_rise (w_rise)
  );

  // Register file
  logic [NumGpio-1:0] r_data_out;
  logic [NumGpio-1:0] r_data_oe;
  logic [NumGpio-1:0] r_intr_state;
  logic [NumGpio-1:0] r_intr_enable;
  logic               r_intr;

  // Response register
  logic               r_d_valid;
  tl_d_op_e           r_d_opcode;
  logic [TL_SZW-1:0]  r_d_size;
  logic [TL_AIW-1:0]  r_d_source;
  logic [TL_DW-1:0]   r_d_data;
  logic               r_d_error;

  // Decode
  logic                 w_a_ready;
  logic                 w_req;
  logic [GpioAddrW-1:0] w_offset;
  logic                 w_is_get;
  logic                 w_is_put;
  logic                 w_err;
  logic                 w_we;
  logic                 w_we_out;
  logic                 w_we_oe;
  logic                 w_we_state;
  logic                 w_we_enable;
  logic                 w_we_test;
  logic [GpioRegW-1:0]  w_bitmask;
  logic [NumGpio-1:0]   w_wmask;
  logic [NumGpio-1:0]   w_wdata;
  logic [GpioRegW-1:0]  w_rdata;

  logic [NumGpio-1:0]   w_data_out_next;
  logic [NumGpio-1:0]   w_data_oe_next;
  logic [NumGpio-1:0]   w_intr_enable_next;
  logic [NumGpio-1:0]   w_intr_state_next;

  // Fields the register block has no use for; address bits above the window
  // are routed by the crossbar.
  logic w_unused;
  assign w_unused = ^{tl_i.a_param, tl_i.a_user, tl_i.a_address[TL_AW-1:GpioAddrW]};

  assign w_a_ready = ~r_d_valid | tl_i.d_ready;
  assign w_req     = tl_i.a_valid & w_a_ready;
  assign w_offset  = tl_i.a_address[GpioAddrW-1:0];
  assign w_is_get  = (tl_i.a_opcode == Get);
  assign w_is_put  = (tl_i.a_opcode == PutFullData) | (tl_i.a_opcode == PutPartialData);

  // Unknown offset, misaligned word, unsupported opcode, or write to the RO input.
  assign w_err = (w_offset > GPIO_LAST_OFFSET)
               | (w_offset[1:0] != 2'b00)
               | ~(w_is_get | w_is_put)
               | (w_is_put & (w_offset == GPIO_DATA_IN));

  assign w_we        = w_req & w_is_put & ~w_err;
  assign w_we_out    = w_we & (w_offset == GPIO_DATA_OUT);
  assign w_we_oe     = w_we & (w_offset == GPIO_DATA_OE);
  assign w_we_state  = w_we & (w_offset == GPIO_INTR_STATE);
  assign w_we_enable = w_we & (w_offset == GPIO_INTR_ENABLE);
  assign w_we_test   = w_we & (w_offset == GPIO_INTR_TEST);

  // Byte enables expanded to bit enables; PutFull and PutPartial both honour them.
  for (genvar gi = 0; gi < TL_DBW; gi++) begin : g_mask
    assign w_bitmask[gi*8 +: 8] = {8{tl_i.a_mask[gi]}};
  end

  assign w_wmask = w_bitmask[NumGpio-1:0];
  assign w_wdata = tl_i.a_data[NumGpio-1:0] & w_wmask;

  assign w_data_out_next    = w_we_out    ? ((r_data_out    & ~w_wmask) | w_wdata) : r_data_out;
  assign w_data_oe_next     = w_we_oe     ? ((r_data_oe     & ~w_wmask) | w_wdata) : r_data_oe;
  assign w_intr_enable_next = w_we_enable ? ((r_intr_enable & ~w_wmask) | w_wdata) : r_intr_enable;

  // Per-bit interrupt state: a hardware edge or a test write outranks a W1C clear.
  for (genvar gi = 0; gi < NumGpio; gi++) begin : g_intr
    assign w_intr_state_next[gi] = w_rise[gi]
                                 | (w_we_test & w_wdata[gi])
                                 | (r_intr_state[gi] & ~(w_we_state & w_wdata[gi]));
  end

  // Read mux; unimplemented bits and the write-only test register return 0.
  always_comb begin
    w_rdata = '0;
    case (w_offset)
      GPIO_DATA_IN:     w_rdata = GpioRegW'(w_data_in);
      GPIO_DATA_OUT:    w_rdata = GpioRegW'(r_data_out);
      GPIO_DATA_OE:     w_rdata = GpioRegW'(r_data_oe);
      GPIO_INTR_STATE:  w_rdata = GpioRegW'(r_intr_state);
      GPIO_INTR_ENABLE: w_rdata = GpioRegW'(r_intr_enable);
      default:          w_rdata = '0;
    endcase
  end

  // Register file update and registered interrupt level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data_out    <= '0;
      r_data_oe     <= '0;
      r_intr_state  <= '0;
      r_intr_enable <= '0;
      r_intr        <= 1'b0;
    end else begin
      r_data_out    <= w_data_out_next;
      r_data_oe     <= w_data_oe_next;
      r_intr_state  <= w_intr_state_next;
      r_intr_enable <= w_intr_enable_next;
      r_intr        <= |(r_intr_state & r_intr_enable);
    end
  end

  // Response register: capture on acceptance, hold while the host stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_d_valid  <= 1'b0;
      r_d_opcode <= AccessAck;
      r_d_size   <= '0;
      r_d_source <= '0;
      r_d_data   <= '0;
      r_d_error  <= 1'b0;
    end else if (w_req) begin
      r_d_valid  <= 1'b1;
      r_d_opcode <= w_is_get ? AccessAckData : AccessAck;
      r_d_size   <= tl_i.a_size;
      r_d_source <= tl_i.a_source;
      r_d_data   <= (w_is_get & ~w_err) ? w_rdata : '0;
      r_d_error  <= w_err;
    end else if (tl_i.d_ready) begin
      r_d_valid  <= 1'b0;
    end
  end

  // Drive the D channel; unused response fields are tied to zero.
  always_comb begin
    tl_o          = '0;
    tl_o.d_valid  = r_d_valid;
    tl_o.d_opcode = r_d_opcode;
    tl_o.d_size   = r_d_size;
    tl_o.d_source = r_d_source;
    tl_o.d_data   = r_d_data;
    tl_o.d_error  = r_d_error;
    tl_o.a_ready  = w_a_ready;
  end

  assign gpio_o    = r_data_out;
  assign gpio_oe_o = r_data_oe;
  assign intr_o    = r_intr;

endmodule

// File: tb/tb_tlul_gpio.sv
// Self-checking bench for tlul_gpio: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_tlul_gpio;
  import tlul_pkg::*;

  localparam int N = 32;

  logic          clk = 1'b0;
  logic          rst;
  tl_h2d_t       tl_h2d;
  tl_d2h_t       tl_d2h;
  logic [N-1:0]  gpio_in;
  logic [N-1:0]  gpio_out;
  logic [N-1:0]  gpio_oe;
  logic          intr;

  int checks   = 0;
  int failures = 0;
  int srcn     = 0;

  tlul_gpio #(.NumGpio(N)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .tl_i      (tl_h2d),
    .tl_o      (tl_d2h),
    .gpio_i    (gpio_in),
    .gpio_o    (gpio_out),
    .gpio_oe_o (gpio_oe),
    .intr_o    (intr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Registers as plain words; pins[k] is gpio_i as seen k+1 clock edges ago.
  bit          m_ok = 0;
  logic [31:0] m_out, m_oe, m_state, m_en;
  logic [31:0] pins [0:2];
  bit          m_intr;
  bit          m_dv;
  tl_d_op_e    m_op;
  logic [31:0] m_data;
  bit          m_err;
  logic [7:0]  m_src;
  logic [1:0]  m_size;

  task automatic model_step();
    logic [31:0] rise, clr, tst, bm, rd, din;
    logic [4:0]  off;
    bit          get, put, err, acc, nxt_intr;
    if (rst) begin
      m_ok = 1; m_out = 0; m_oe = 0; m_state = 0; m_en = 0; m_intr = 0; m_dv = 0;
      m_op = AccessAck; m_data = 0; m_err = 0; m_src = 0; m_size = 0;
      for (int k = 0; k < 3; k++) pins[k] = 0;
    end else begin
      din      = pins[1];
      rise     = pins[1] & ~pins[2];
      clr      = 0;
      tst      = 0;
      nxt_intr = |(m_state & m_en);
      acc      = tl_h2d.a_valid && (!m_dv || tl_h2d.d_ready);
      if (m_dv && tl_h2d.d_ready) m_dv = 0;
      if (acc) begin
        off = tl_h2d.a_address[4:0];
        get = (tl_h2d.a_opcode == Get);
        put = (tl_h2d.a_opcode == PutFullData) || (tl_h2d.a_opcode == PutPartialData);
        err = (off > 5'h14) || (off[1:0] != 2'b00) || !(get || put) || (put && off == 5'h00);
        for (int b = 0; b < 4; b++) bm[8*b +: 8] = {8{tl_h2d.a_mask[b]}};
        rd = 0;
        if (get && !err) begin
          case (off)
            5'h00: rd = din;
            5'h04: rd = m_out;
            5'h08: rd = m_oe;
            5'h0C: rd = m_state;
            5'h10: rd = m_en;
            default: rd = 0;
          endcase
        end
        if (put && !err) begin
          case (off)
            5'h04: m_out = (m_out & ~bm) | (tl_h2d.a_data & bm);
            5'h08: m_oe  = (m_oe  & ~bm) | (tl_h2d.a_data & bm);
            5'h0C: clr   = tl_h2d.a_data & bm;
            5'h10: m_en  = (m_en  & ~bm) | (tl_h2d.a_data & bm);
            5'h14: tst   = tl_h2d.a_data & bm;
            default: ;
          endcase
        end
        m_dv   = 1;
        m_op   = get ? AccessAckData : AccessAck;
        m_data = rd;
        m_err  = err;
        m_src  = tl_h2d.a_source;
        m_size = tl_h2d.a_size;
      end
      m_state = (m_state & ~clr) | rise | tst;
      m_intr  = nxt_intr;
      pins[2] = pins[1];
      pins[1] = pins[0];
      pins[0] = gpio_in;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Compare every cycle on the falling edge, once the model has seen a reset.
  initial begin
    forever begin
      @(negedge clk);
      if (m_ok) begin
        chk("gpio_o", gpio_out, m_out);
        chk("gpio_oe_o", gpio_oe, m_oe);
        chk("intr_o", 32'(intr), 32'(m_intr));
        chk("d_valid", 32'(tl_d2h.d_valid), 32'(m_dv));
        chk("a_ready", 32'(tl_d2h.a_ready), 32'(!m_dv || tl_h2d.d_ready));
        if (m_dv) begin
          chk("d_opcode", 32'(tl_d2h.d_opcode), 32'(m_op));
          chk("d_data", tl_d2h.d_data, m_data);
          chk("d_error", 32'(tl_d2h.d_error), 32'(m_err));
          chk("d_source", 32'(tl_d2h.d_source), 32'(m_src));
          chk("d_size", 32'(tl_d2h.d_size), 32'(m_size));
          chk("d_zero_fields", 32'({tl_d2h.d_param, tl_d2h.d_sink, tl_d2h.d_user}), 32'h0);
          if (tl_h2d.d_ready)
            $display("txn src=%0d op=%0d err=%0b data=%08h", tl_d2h.d_source,
                     tl_d2h.d_opcode, tl_d2h.d_error, tl_d2h.d_data);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input tl_a_op_e op, input logic [31:0] addr,
                     input logic [3:0] mask, input logic [31:0] data);
    tl_h2d.a_valid   = 1'b1;
    tl_h2d.a_opcode  = op;
    tl_h2d.a_param   = 3'b0;
    tl_h2d.a_size    = 2'd2;
    tl_h2d.a_source  = 8'(srcn);
    tl_h2d.a_address = addr;
    tl_h2d.a_mask    = mask;
    tl_h2d.a_data    = data;
    tl_h2d.a_user    = '0;
    srcn++;
  endtask

  task automatic idle();
    tl_h2d.a_valid = 1'b0;
  endtask

  initial begin
    int          pick;
    int          off;
    logic [31:0] addr;
    tl_a_op_e    op;

    rst            = 1'b1;
    tl_h2d         = '0;
    tl_h2d.d_ready = 1'b1;
    gpio_in        = '0;

    // Reset with pins toggling
    for (int i = 0; i < 2; i++) begin
      gpio_in = ~gpio_in ^ $urandom();
      cyc();
    end
    chk("rst_gpio_o", gpio_out, 32'h0);
    chk("rst_gpio_oe", gpio_oe, 32'h0);
    chk("rst_intr", 32'(intr), 32'h0);
    chk("rst_d_valid", 32'(tl_d2h.d_valid), 32'h0);
    chk("rst_a_ready", 32'(tl_d2h.a_ready), 32'h1);
    rst     = 1'b0;
    gpio_in = '0;
    cyc(); cyc(); cyc();

    // Back-to-back write then read
    req(PutFullData, 32'h04, 4'hF, 32'hA5A5_00FF); cyc();
    chk("wr_gpio_o", gpio_out, 32'hA5A5_00FF);
    chk("wr_ack_op", 32'(tl_d2h.d_opcode), 32'(AccessAck));
    req(Get, 32'h04, 4'hF, 32'h0); cyc();
    chk("rd_valid", 32'(tl_d2h.d_valid), 32'h1);
    chk("rd_op", 32'(tl_d2h.d_opcode), 32'(AccessAckData));
    chk("rd_data", tl_d2h.d_data, 32'hA5A5_00FF);

    // Partial write of byte 1 only
    req(PutPartialData, 32'h08, 4'b0010, 32'hFFFF_FFFF); cyc();
    chk("partial_oe", gpio_oe, 32'h0000_FF00);

    // Error responses
    req(Get, 32'h18, 4'hF, 32'h0); cyc();
    chk("err_get18", 32'(tl_d2h.d_error), 32'h1);
    chk("err_get18_data", tl_d2h.d_data, 32'h0);
    req(PutFullData, 32'h02, 4'hF, 32'hFFFF_FFFF); cyc();
    chk("err_put02", 32'(tl_d2h.d_error), 32'h1);
    req(PutFullData, 32'h00, 4'hF, 32'hFFFF_FFFF); cyc();
    chk("err_put00", 32'(tl_d2h.d_error), 32'h1);
    chk("err_put00_data", tl_d2h.d_data, 32'h0);
    idle(); cyc();
    chk("err_keep_out", gpio_out, 32'hA5A5_00FF);
    chk("err_keep_oe", gpio_oe, 32'h0000_FF00);

    // Interrupt from pin 0 rising edge
    req(PutFullData, 32'h10, 4'hF, 32'h1); cyc(); idle();
    gpio_in = 32'h1;
    cyc(); cyc(); cyc();
    chk("irq_3cyc", 32'(intr), 32'h0);
    cyc();
    chk("irq_4cyc", 32'(intr), 32'h1);
    req(PutFullData, 32'h0C, 4'hF, 32'h1); cyc(); idle();
    chk("w1c_same_cycle", 32'(intr), 32'h1);
    cyc();
    chk("w1c_next", 32'(intr), 32'h0);

    // W1C landing on the same edge as a new rising edge
    gpio_in = 32'h0; cyc(); cyc(); cyc();
    gpio_in = 32'h1; cyc(); cyc();
    req(PutFullData, 32'h0C, 4'hF, 32'h1); cyc();
    req(Get, 32'h0C, 4'hF, 32'h0); cyc(); idle();
    chk("edge_beats_w1c", tl_d2h.d_data, 32'h1);
    req(PutFullData, 32'h0C, 4'hF, 32'h1); cyc(); idle();
    cyc(); cyc();

    // Backpressure: response must hold, a_ready low, queued Put not taken
    tl_h2d.d_ready = 1'b0;
    req(Get, 32'h04, 4'hF, 32'h0); cyc();
    req(PutFullData, 32'h04, 4'hF, 32'h0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(tl_d2h.d_valid), 32'h1);
      chk("bp_op", 32'(tl_d2h.d_opcode), 32'(AccessAckData));
      chk("bp_data", tl_d2h.d_data, 32'hA5A5_00FF);
      chk("bp_a_ready", 32'(tl_d2h.a_ready), 32'h0);
      gpio_in = $urandom();
      cyc();
    end
    chk("bp_keep_out", gpio_out, 32'hA5A5_00FF);
    idle();
    rst = 1'b1; cyc();
    chk("rst_drop", 32'(tl_d2h.d_valid), 32'h0);
    rst            = 1'b0;
    tl_h2d.d_ready = 1'b1;
    gpio_in        = '0;
    cyc();

    // Randomized traffic checked by the model every cycle
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 99) < 70) begin
        pick = $urandom_range(0, 9);
        if (pick < 4)      op = Get;
        else if (pick < 7) op = PutFullData;
        else if (pick < 9) op = PutPartialData;
        else               op = tl_a_op_e'(3'($urandom_range(2, 5)));
        if ($urandom_range(0, 9) == 0) off = $urandom_range(0, 31);
        else                           off = 4 * $urandom_range(0, 6);
        addr      = $urandom();
        addr[4:0] = 5'(off);
        req(op, addr, 4'($urandom()), $urandom());
      end else begin
        idle();
      end
      tl_h2d.d_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) gpio_in = gpio_in ^ $urandom();
      rst = ($urandom_range(0, 199) == 0);
      cyc();
    end

    idle();
    rst            = 1'b0;
    tl_h2d.d_ready = 1'b1;
    cyc(); cyc();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
